// File: rtl/alu_seq.sv
// Clocked ALU for the execute stage. Single-cycle ops finish in one cycle, and
// multiply, divide and remainder iterate one bit per cycle behind Busy.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Ovf,
  output logic             DivZero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_DIVU = 4'b0110;
  localparam logic [3:0] OP_REMU = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1100;
  localparam logic [3:0] OP_ROR  = 4'b1101;

  localparam logic [SHW:0] CNT_INIT = WIDTH[SHW:0];

  logic [1:0]       state_reg, state_next;
  logic [3:0]       op_reg, op_next;
  logic [SHW:0]     cnt_reg, cnt_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             ovf_reg, ovf_next;
  logic             dz_reg, dz_next;

  logic [SHW-1:0]   sh;
  logic [SHW:0]     rsh;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf, alu_dz, multi;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub, div_rem, div_quo;
  logic             div_ge;

  // Single-cycle datapath straight from the input operands.
  always_comb begin
    sh      = B[SHW-1:0];
    rsh     = CNT_INIT - {1'b0, sh};
    sum     = A + B;
    diff    = A - B;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_dz  = 1'b0;
    case (Op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NOT:  alu_res = ~A;
      OP_SRA:  alu_res = $signed(A) >>> sh;
      OP_SRL:  alu_res = A >> sh;
      OP_SLL:  alu_res = A << sh;
      // A shift by rsh == WIDTH yields zero, so amount 0 returns A.
      OP_ROL:  alu_res = (A << sh) | (A >> rsh);
      OP_ROR:  alu_res = (A >> sh) | (A << rsh);
      OP_DIVU: begin
        alu_res = '1;
        alu_dz  = 1'b1;
      end
      OP_REMU: begin
        alu_res = A;
        alu_dz  = 1'b1;
      end
      default: alu_res = '0;
    endcase
    multi = (Op == OP_MUL) || (((Op == OP_DIVU) || (Op == OP_REMU)) && (B != '0));
  end

  // Iteration step: acc is the product or partial remainder, opa the
  // multiplicand or dividend/quotient, opb the multiplier or divisor.
  always_comb begin
    mul_acc = acc_reg + (opb_reg[0] ? opa_reg : '0);
    rem_sh  = {acc_reg, opa_reg[WIDTH-1]};
    div_ge  = rem_sh >= {1'b0, opb_reg};
    rem_sub = rem_sh[WIDTH-1:0] - opb_reg;
    div_rem = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
    div_quo = {opa_reg[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    out_next   = out_reg;
    ovf_next   = ovf_reg;
    dz_next    = dz_reg;
    case (state_reg)
      RUN: begin
        cnt_next = cnt_reg - 1'b1;
        if (op_reg == OP_MUL) begin
          acc_next = mul_acc;
          opa_next = opa_reg << 1;
          opb_next = opb_reg >> 1;
        end else begin
          acc_next = div_rem;
          opa_next = div_quo;
        end
        if (cnt_reg == 1) begin
          state_next = DONE;
          ovf_next   = 1'b0;
          dz_next    = 1'b0;
          if (op_reg == OP_MUL)       out_next = mul_acc;
          else if (op_reg == OP_DIVU) out_next = div_quo;
          else                        out_next = div_rem;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        if (Start) begin
          if (multi) begin
            state_next = RUN;
            op_next    = Op;
            cnt_next   = CNT_INIT;
            acc_next   = '0;
            opa_next   = A;
            opb_next   = B;
          end else begin
            state_next = DONE;
            out_next   = alu_res;
            ovf_next   = alu_ovf;
            dz_next    = alu_dz;
          end
        end else begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      out_reg   <= '0;
      ovf_reg   <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      out_reg   <= out_next;
      ovf_reg   <= ovf_next;
      dz_reg    <= dz_next;
    end
  end

  assign Busy    = (state_reg == RUN);
  assign Done    = (state_reg == DONE);
  assign Out     = out_reg;
  assign Zero    = (out_reg == '0);
  assign Ovf     = ovf_reg;
  assign DivZero = dz_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake corner
// sequences and random ops against an arithmetic reference model.
module tb_alu_seq;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [31:0] A, B;
  logic [3:0]  Op;
  logic        Busy, Done, Zero, Ovf, DivZero;
  logic [31:0] Out;

  int n_err = 0;
  int n_chk = 0;

  alu_seq #(.WIDTH(32), .SHW(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .Op(Op),
    .Busy(Busy), .Done(Done), .Out(Out), .Zero(Zero), .Ovf(Ovf),
    .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, out;
    logic        ovf, dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string nm, input logic [3:0] op, input logic [31:0] a, b, out,
                         input logic ovf, dz, input int lat);
    vec_t v;
    v.name = nm; v.op = op; v.a = a; v.b = b; v.out = out;
    v.ovf = ovf; v.dz = dz; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: results from plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, b,
                                output logic [31:0] r, output logic ov, dz, output int lat);
    logic [63:0] p;
    longint      t;
    int          s;
    s   = int'(b % 32);
    r   = '0;
    ov  = 1'b0;
    dz  = 1'b0;
    lat = 1;
    case (op)
      4'd0: begin
        r  = a + b;
        t  = longint'($signed(a)) + longint'($signed(b));
        ov = (t != longint'($signed(r)));
      end
      4'd1: begin
        r  = a - b;
        t  = longint'($signed(a)) - longint'($signed(b));
        ov = (t != longint'($signed(r)));
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~a;
      4'd5: begin
        p   = {32'd0, a} * {32'd0, b};
        r   = p[31:0];
        lat = 33;
      end
      4'd6: if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
            else begin r = a / b; lat = 33; end
      4'd7: if (b == 0) begin r = a; dz = 1'b1; end
            else begin r = a % b; lat = 33; end
      4'd8: r = $signed(a) >>> s;
      4'd9: r = a >> s;
      4'd10: r = a << s;
      4'd12: begin
        r = a;
        for (int k = 0; k < s; k++) r = {r[30:0], r[31]};
      end
      4'd13: begin
        r = a;
        for (int k = 0; k < s; k++) r = {r[0], r[31:1]};
      end
      default: r = '0;
    endcase
  endfunction

  // Issue one op, wait for Done (bounded), and compare everything.
  task automatic run_exp(input string nm, input logic [3:0] op, input logic [31:0] a, b, eo,
                         input logic eov, edz, input int elat);
    int lat;
    int busy_bad;
    Op = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
    lat = 1;
    busy_bad = 0;
    while (!Done && lat < 100) begin
      if (Busy !== (elat > 1)) busy_bad++;
      tick();
      lat++;
    end
    $display("op=%h a=%h b=%h out=%h ovf=%b dz=%b lat=%0d (%s)", op, a, b, Out, Ovf, DivZero, lat, nm);
    check({nm, " latency"}, 32'(lat), 32'(elat));
    check({nm, " busy"}, 32'(busy_bad), 32'd0);
    check({nm, " busy_at_done"}, {31'd0, Busy}, 32'd0);
    check({nm, " out"}, Out, eo);
    check({nm, " ovf"}, {31'd0, Ovf}, {31'd0, eov});
    check({nm, " divzero"}, {31'd0, DivZero}, {31'd0, edz});
    check({nm, " zero"}, {31'd0, Zero}, {31'd0, eo == 0});
  endtask

  task automatic run_model(input string nm, input logic [3:0] op, input logic [31:0] a, b);
    logic [31:0] eo;
    logic        eov, edz;
    int          elat;
    model(op, a, b, eo, eov, edz, elat);
    run_exp(nm, op, a, b, eo, eov, edz, elat);
  endtask

  initial begin
    logic [31:0] b2b_exp [5];
    int          lat;
    int          busy_bad;
    int          dones;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    add_vec("add_ovf",   4'd0,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1, 1'b0, 1);
    add_vec("sub_ovf",   4'd1,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    add_vec("add_wrap",  4'd0,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0, 1'b0, 1);
    add_vec("sub_neg",   4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    add_vec("mul_7x6",   4'd5,  32'd7,         32'd6,         32'd42,        1'b0, 1'b0, 33);
    add_vec("mul_wrap",  4'd5,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b0, 1'b0, 33);
    add_vec("divu",      4'd6,  32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 33);
    add_vec("remu",      4'd7,  32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 33);
    add_vec("remu_dz",   4'd7,  32'd5,         32'd0,         32'd5,         1'b0, 1'b1, 1);
    add_vec("divu_dz",   4'd6,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    add_vec("divu_by1",  4'd6,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    add_vec("remu_small",4'd7,  32'd7,         32'd100,       32'd7,         1'b0, 1'b0, 33);
    add_vec("sra4",      4'd8,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0, 1);
    add_vec("sra0",      4'd8,  32'h8000_0000, 32'd32,        32'h8000_0000, 1'b0, 1'b0, 1);
    add_vec("srl31",     4'd9,  32'h8000_0000, 32'd31,        32'd1,         1'b0, 1'b0, 1);
    add_vec("sll31",     4'd10, 32'd1,         32'd31,        32'h8000_0000, 1'b0, 1'b0, 1);
    add_vec("rol1",      4'd12, 32'h8000_0001, 32'd1,         32'h0000_0003, 1'b0, 1'b0, 1);
    add_vec("ror4",      4'd13, 32'h8000_0001, 32'd4,         32'h1800_0000, 1'b0, 1'b0, 1);
    add_vec("rol0",      4'd12, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b0, 1'b0, 1);
    add_vec("undef",     4'd11, 32'h1234_5678, 32'h0000_0001, 32'd0,         1'b0, 1'b0, 1);

    Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
    repeat (3) tick();
    Reset = 1'b0;
    check("reset busy",    {31'd0, Busy},    32'd0);
    check("reset done",    {31'd0, Done},    32'd0);
    check("reset out",     Out,              32'd0);
    check("reset zero",    {31'd0, Zero},    32'd1);
    check("reset ovf",     {31'd0, Ovf},     32'd0);
    check("reset divzero", {31'd0, DivZero}, 32'd0);
    tick();

    // Back-to-back single-cycle ops with Start held high.
    b2b_exp = '{32'd3, 32'd1, 32'd0, 32'd3, 32'hFFFF_FFFD};
    for (int i = 0; i < 5; i++) begin
      Op = 4'(i); A = 32'd2; B = 32'd1; Start = 1'b1;
      tick();
      $display("b2b op=%0d out=%h done=%b zero=%b", i, Out, Done, Zero);
      check("b2b done", {31'd0, Done}, 32'd1);
      check("b2b out",  Out, b2b_exp[i]);
      check("b2b zero", {31'd0, Zero}, {31'd0, i == 2});
    end
    Start = 1'b0;
    tick();
    check("done one cycle", {31'd0, Done}, 32'd0);

    foreach (vecs[i])
      run_exp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out,
              vecs[i].ovf, vecs[i].dz, vecs[i].lat);
    tick();

    // Start during RUN is ignored; Start on the Done cycle is accepted.
    Op = 4'd5; A = 32'd7; B = 32'd6; Start = 1'b1;
    tick();
    lat = 1;
    busy_bad = 0;
    while (!Done && lat < 100) begin
      if (Busy !== 1'b1) busy_bad++;
      if (lat == 5) begin
        Op = 4'd0; A = 32'd1; B = 32'd1; Start = 1'b1;
      end else begin
        Start = 1'b0; A = $urandom; B = $urandom;
      end
      tick();
      lat++;
    end
    $display("mul_ignore out=%h lat=%0d", Out, lat);
    check("mul_ignore latency", 32'(lat), 32'd33);
    check("mul_ignore busy", 32'(busy_bad), 32'd0);
    check("mul_ignore out", Out, 32'd42);
    Op = 4'd0; A = 32'd5; B = 32'd6; Start = 1'b1;
    tick();
    Start = 1'b0;
    $display("start_on_done out=%h done=%b", Out, Done);
    check("start_on_done done", {31'd0, Done}, 32'd1);
    check("start_on_done out", Out, 32'd11);
    tick();

    // Reset in the middle of a divide aborts it silently.
    Op = 4'd6; A = 32'd100; B = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    check("pre_reset busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    $display("abort busy=%b done=%b out=%h zero=%b", Busy, Done, Out, Zero);
    check("abort busy", {31'd0, Busy}, 32'd0);
    check("abort done", {31'd0, Done}, 32'd0);
    check("abort out",  Out, 32'd0);
    check("abort zero", {31'd0, Zero}, 32'd1);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) dones++;
      tick();
    end
    check("abort no_done", 32'(dones), 32'd0);
    run_exp("sra_after_abort", 4'd8, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1);

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) tick();
      run_model("rand", rop, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
